// File: rtl/sao_stat_scan_ctrl.sv
// SAO statistics scan sequencer: walks CTUs in raster order, cIdx 0..2 per CTU,
// and 2x2 blocks per component, clipping the block grid at the picture edges.
module sao_stat_scan_ctrl #(
    parameter int pic_width_len  = 13,
    parameter int pic_height_len = 13,
    parameter int ctu_x_len      = 9,
    parameter int ctu_y_len      = 9,
    parameter int blk_X_len      = 6,
    parameter int blk_Y_len      = 6
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      start,
    input  logic [pic_width_len-1:0]  pic_width,
    input  logic [pic_height_len-1:0] pic_height,
    input  logic [2:0]                ctu_size,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ctu_x_len-1:0]      ctu_x,
    output logic [ctu_y_len-1:0]      ctu_y,
    output logic [blk_X_len-1:0]      X,
    output logic [blk_Y_len-1:0]      Y,
    output logic [1:0]                cIdx,
    output logic [2:0]                ctu_size_o,
    output logic                      blk_last,
    output logic                      ctu_done,
    output logic                      pic_done,
    output logic                      busy,
    output logic                      cfg_err,
    output logic [1:0]                state_dbg
);
    // Handshake: a block position transfers on a rising clk edge where out_valid
    // and out_ready are both high; position outputs hold while out_valid & !out_ready.

    localparam int WW = pic_width_len + 1;
    localparam int HW = pic_height_len + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, CDONE} state_t;
    state_t state;

    logic [pic_width_len-1:0]  pic_w_r;
    logic [pic_height_len-1:0] pic_h_r;
    logic [blk_X_len-1:0]      nx_m1;
    logic [blk_Y_len-1:0]      ny_m1;

    logic [WW-1:0] span_w, org_x, rem_w, cw, nx, ncol;
    logic [HW-1:0] span_h, org_y, rem_h, ch, ny, nrow;
    logic          last_col, last_row, last_x, last_y, size_ok;

    always_comb begin
        span_w   = WW'(1) << ctu_size_o;
        span_h   = HW'(1) << ctu_size_o;
        org_x    = WW'(ctu_x) << ctu_size_o;
        org_y    = HW'(ctu_y) << ctu_size_o;
        // One extra bit keeps the edge remainder from wrapping.
        rem_w    = {1'b0, pic_w_r} - org_x;
        rem_h    = {1'b0, pic_h_r} - org_y;
        cw       = (rem_w < span_w) ? rem_w : span_w;
        ch       = (rem_h < span_h) ? rem_h : span_h;
        nx       = (cIdx == 2'd0) ? (cw >> 1) : (cw >> 2);
        ny       = (cIdx == 2'd0) ? (ch >> 1) : (ch >> 2);
        ncol     = ({1'b0, pic_w_r} + span_w - WW'(1)) >> ctu_size_o;
        nrow     = ({1'b0, pic_h_r} + span_h - HW'(1)) >> ctu_size_o;
        last_col = (WW'(ctu_x) == ncol - WW'(1));
        last_row = (HW'(ctu_y) == nrow - HW'(1));
        last_x   = (X == nx_m1);
        last_y   = (Y == ny_m1);
        size_ok  = (ctu_size >= 3'd4) && (ctu_size <= 3'd6);
    end

    assign blk_last  = (state == SCAN) && last_x && last_y;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            pic_w_r    <= '0;
            pic_h_r    <= '0;
            ctu_size_o <= '0;
            nx_m1      <= '0;
            ny_m1      <= '0;
            ctu_x      <= '0;
            ctu_y      <= '0;
            X          <= '0;
            Y          <= '0;
            cIdx       <= '0;
            out_valid  <= 1'b0;
            ctu_done   <= 1'b0;
            pic_done   <= 1'b0;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err  <= 1'b0;
            ctu_done <= 1'b0;
            pic_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (size_ok) begin
                            pic_w_r    <= pic_width;
                            pic_h_r    <= pic_height;
                            ctu_size_o <= ctu_size;
                            busy       <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    nx_m1     <= blk_X_len'(nx - WW'(1));
                    ny_m1     <= blk_Y_len'(ny - HW'(1));
                    X         <= '0;
                    Y         <= '0;
                    out_valid <= 1'b1;
                    state     <= SCAN;
                end
                SCAN: begin
                    if (out_ready) begin
                        if (!last_x) begin
                            X <= X + blk_X_len'(1);
                        end else begin
                            X <= '0;
                            if (!last_y) begin
                                Y <= Y + blk_Y_len'(1);
                            end else begin
                                Y         <= '0;
                                out_valid <= 1'b0;
                                if (cIdx != 2'd2) begin
                                    cIdx  <= cIdx + 2'd1;
                                    state <= LOAD;
                                end else begin
                                    ctu_done <= 1'b1;
                                    pic_done <= last_col && last_row;
                                    state    <= CDONE;
                                end
                            end
                        end
                    end
                end
                CDONE: begin
                    cIdx <= '0;
                    if (last_col && last_row) begin
                        busy  <= 1'b0;
                        ctu_x <= '0;
                        ctu_y <= '0;
                        state <= IDLE;
                    end else begin
                        if (last_col) begin
                            ctu_x <= '0;
                            ctu_y <= ctu_y + ctu_y_len'(1);
                        end else begin
                            ctu_x <= ctu_x + ctu_x_len'(1);
                        end
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sao_stat_scan_ctrl.sv
// Bench for sao_stat_scan_ctrl: table of picture configs with hand-computed
// beat/CTU totals, a beat-order scoreboard, plus reset and config-error sequences.
module tb_sao_stat_scan_ctrl;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [12:0] pic_width;
    logic [12:0] pic_height;
    logic [2:0]  ctu_size;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  ctu_x;
    logic [8:0]  ctu_y;
    logic [5:0]  X;
    logic [5:0]  Y;
    logic [1:0]  cIdx;
    logic [2:0]  ctu_size_o;
    logic        blk_last;
    logic        ctu_done;
    logic        pic_done;
    logic        busy;
    logic        cfg_err;
    logic [1:0]  state_dbg;

    sao_stat_scan_ctrl dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .pic_width(pic_width), .pic_height(pic_height), .ctu_size(ctu_size),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctu_x(ctu_x), .ctu_y(ctu_y), .X(X), .Y(Y), .cIdx(cIdx),
        .ctu_size_o(ctu_size_o), .blk_last(blk_last), .ctu_done(ctu_done),
        .pic_done(pic_done), .busy(busy), .cfg_err(cfg_err), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard: {ctu_x, ctu_y, X, Y, cIdx, blk_last}
    logic [32:0] exp_q[$];
    int          done_q[$];

    typedef struct {
        int w;
        int h;
        int s;
        int ready_pct;
        int exp_beats;
        int exp_ctus;
        int inject_at;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [32:0] pos_pack();
        return {ctu_x, ctu_y, X, Y, cIdx, blk_last};
    endfunction

    task automatic build_model(input int w, input int h, input int s);
        int ncol, nrow, cw, ch, nx, ny, total;
        exp_q.delete();
        done_q.delete();
        total = 0;
        ncol = (w + (1 << s) - 1) >> s;
        nrow = (h + (1 << s) - 1) >> s;
        for (int cy = 0; cy < nrow; cy++) begin
            for (int cx = 0; cx < ncol; cx++) begin
                cw = w - (cx << s);
                if (cw > (1 << s)) cw = 1 << s;
                ch = h - (cy << s);
                if (ch > (1 << s)) ch = 1 << s;
                for (int c = 0; c < 3; c++) begin
                    nx = (c == 0) ? cw / 2 : cw / 4;
                    ny = (c == 0) ? ch / 2 : ch / 4;
                    for (int y = 0; y < ny; y++) begin
                        for (int x = 0; x < nx; x++) begin
                            exp_q.push_back({9'(cx), 9'(cy), 6'(x), 6'(y), 2'(c),
                                             (x == nx - 1) && (y == ny - 1)});
                            total++;
                        end
                    end
                end
                done_q.push_back(total);
            end
        end
    endtask

    // drive one picture; abort_at > 0 leaves the scan running after that many beats
    task automatic run_pic(input int w, input int h, input int s, input int pct,
                           input int exp_beats, input int exp_ctus,
                           input int inject_at, input int abort_at);
        int          beats, ctus, cyc, budget;
        bit          seen_pic, stalled, injected;
        logic [32:0] prev, cur;
        build_model(w, h, s);
        beats = 0; ctus = 0; cyc = 0; seen_pic = 0; stalled = 0; injected = 0;
        prev = '0;
        budget = 5 * exp_beats + 500;
        pic_width = 13'(w); pic_height = 13'(h); ctu_size = 3'(s);
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("valid_in_load", out_valid, 0);
        @(negedge clk);
        check("first_valid", out_valid, 1);
        while (!seen_pic && cyc < budget) begin
            start = 1'b0;
            cur = pos_pack();
            if (stalled) begin
                check("hold_pos", cur, prev);
                check("hold_valid", out_valid, 1);
            end
            check("pic_without_ctu", pic_done & ~ctu_done, 0);
            if (ctu_done) begin
                ctus++;
                if (done_q.size() == 0) check("extra_ctu_done", 1, 0);
                else check("ctu_done_beats", beats, done_q.pop_front());
                check("pic_done_on_last", pic_done, ctus == exp_ctus);
                if (pic_done) seen_pic = 1;
            end
            if (abort_at > 0 && beats == abort_at) begin
                out_ready = 1'b0;
                break;
            end
            if (inject_at > 0 && beats == inject_at && !injected) begin
                injected = 1;
                start = 1'b1;
                pic_width = 13'd8; pic_height = 13'd8; ctu_size = 3'd6;
            end
            out_ready = ($urandom_range(0, 99) < pct);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else check("beat", cur, exp_q.pop_front());
                beats++;
            end
            stalled = out_valid && !out_ready;
            prev = cur;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (abort_at == 0) begin
            check("pic_done_seen", seen_pic, 1);
            check("beat_total", beats, exp_beats);
            check("ctu_total", ctus, exp_ctus);
            check("queue_empty", exp_q.size(), 0);
            check("busy_after_pic", busy, 0);
            check("valid_after_pic", out_valid, 0);
            check("pos_after_pic", pos_pack(), 0);
            check("pic_done_width", pic_done, 0);
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{64, 64, 5, 100, 1536, 4, 0};
        vecs[1] = '{72, 40, 5, 100, 1080, 6, 0};
        vecs[2] = '{64, 64, 5,  30, 1536, 4, 0};
        vecs[3] = '{ 8,  8, 4, 100,   24, 1, 0};
        vecs[4] = '{48, 24, 4, 100,  432, 6, 50};
        vecs[5] = '{40, 16, 6,  70,  240, 1, 0};

        arst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        pic_width = '0; pic_height = '0; ctu_size = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pos", pos_pack(), 0);
        check("rst_size", ctu_size_o, 0);
        check("rst_pulses", {ctu_done, pic_done, cfg_err}, 0);
        arst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_pic(vecs[i].w, vecs[i].h, vecs[i].s, vecs[i].ready_pct,
                    vecs[i].exp_beats, vecs[i].exp_ctus, vecs[i].inject_at, 0);
            if (vecs[i].inject_at > 0) check("cfg_unchanged", ctu_size_o, vecs[i].s);
            @(negedge clk);
        end

        // illegal ctu_size in IDLE
        for (int k = 0; k < 3; k++) begin
            ctu_size = (k == 0) ? 3'd3 : (k == 1) ? 3'd7 : 3'd0;
            pic_width = 13'd64; pic_height = 13'd64;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("cfg_err_pulse", cfg_err, 1);
            check("cfg_err_busy", busy, 0);
            @(negedge clk);
            check("cfg_err_clear", cfg_err, 0);
            check("cfg_err_idle", busy, 0);
        end

        // reset in the middle of a scan
        run_pic(64, 64, 5, 100, 1536, 4, 0, 200);
        arst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_pos", pos_pack(), 0);
        check("abort_pulses", {ctu_done, pic_done}, 0);
        @(negedge clk);
        arst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_quiet", {ctu_done, pic_done, busy, out_valid}, 0);
        end
        run_pic(64, 64, 5, 100, 1536, 4, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
